// File: rtl/morse_code_decoder.sv
// Straight-key Morse receiver: debounces the key, times marks and gaps in dit units,
// and emits PS/2 set-2 make codes for each character and word gap.
//
// state | meaning
// IDLE  | key up, nothing pending
// MARK  | key down, timing a mark
// SPACE | key up, timing the gap after a mark
// EMIT  | one cycle that clears the symbol buffer after a character
module morse_code_decoder #(
  parameter int UNIT_CYCLES     = 1200000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       key_out,
  output logic [7:0] code_out,
  output logic       code_strb,
  output logic       err_strb
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [DW-1:0] DB_LOAD   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_EMIT} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sync_q;
  logic            sync_d;
  logic [DW-1:0]   db_cnt;
  logic            key_sync, db_fire, rise, fall;
  logic [UW-1:0]   cyc_cnt;
  logic [3:0]      units;
  logic            unit_wrap, is_dah;
  logic [5:0]      pattern;
  logic [2:0]      sym_len;
  logic            ovf, word_pend;
  logic            append, emit_char, emit_word, clr_buf;
  logic [8:0]      tab_hit;
  logic            char_ok;

  assign key_sync = sync_q[1];
  assign db_fire  = (key_sync == sync_d) && (key_sync != key_out) && (db_cnt == '0);
  assign rise     = db_fire & key_sync;
  assign fall     = db_fire & ~key_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      sync_d  <= 1'b0;
      db_cnt  <= '0;
      key_out <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_in};
      sync_d <= key_sync;
      if ((key_sync != sync_d) || (key_sync == key_out))
        db_cnt <= DB_LOAD;
      else if (db_cnt != '0)
        db_cnt <= db_cnt - DW'(1);
      if (db_fire)
        key_out <= key_sync;
    end
  end

  assign unit_wrap = (cyc_cnt == UNIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      units   <= '0;
    end else if (db_fire) begin
      cyc_cnt <= '0;
      units   <= '0;
    end else if (unit_wrap) begin
      cyc_cnt <= '0;
      if (units != 4'd15)
        units <= units + 4'd1;
    end else begin
      cyc_cnt <= cyc_cnt + UW'(1);
    end
  end

  // a unit completing on the same cycle as the fall still counts toward the mark
  assign is_dah = (units >= 4'd2) || ((units == 4'd1) && unit_wrap);

  function automatic logic [8:0] lookup(input logic [2:0] len, input logic [5:0] pat);
    case ({len, pat})
      {3'd2, 6'b000001}: lookup = {1'b1, 8'h1C};
      {3'd4, 6'b001000}: lookup = {1'b1, 8'h32};
      {3'd4, 6'b001010}: lookup = {1'b1, 8'h21};
      {3'd3, 6'b000100}: lookup = {1'b1, 8'h23};
      {3'd1, 6'b000000}: lookup = {1'b1, 8'h24};
      {3'd4, 6'b000010}: lookup = {1'b1, 8'h2B};
      {3'd3, 6'b000110}: lookup = {1'b1, 8'h34};
      {3'd4, 6'b000000}: lookup = {1'b1, 8'h33};
      {3'd2, 6'b000000}: lookup = {1'b1, 8'h43};
      {3'd4, 6'b000111}: lookup = {1'b1, 8'h3B};
      {3'd3, 6'b000101}: lookup = {1'b1, 8'h42};
      {3'd4, 6'b000100}: lookup = {1'b1, 8'h4B};
      {3'd2, 6'b000011}: lookup = {1'b1, 8'h3A};
      {3'd2, 6'b000010}: lookup = {1'b1, 8'h31};
      {3'd3, 6'b000111}: lookup = {1'b1, 8'h44};
      {3'd4, 6'b000110}: lookup = {1'b1, 8'h4D};
      {3'd4, 6'b001101}: lookup = {1'b1, 8'h15};
      {3'd3, 6'b000010}: lookup = {1'b1, 8'h2D};
      {3'd3, 6'b000000}: lookup = {1'b1, 8'h1B};
      {3'd1, 6'b000001}: lookup = {1'b1, 8'h2C};
      {3'd3, 6'b000001}: lookup = {1'b1, 8'h3C};
      {3'd4, 6'b000001}: lookup = {1'b1, 8'h2A};
      {3'd3, 6'b000011}: lookup = {1'b1, 8'h1D};
      {3'd4, 6'b001001}: lookup = {1'b1, 8'h22};
      {3'd4, 6'b001011}: lookup = {1'b1, 8'h35};
      {3'd4, 6'b001100}: lookup = {1'b1, 8'h1A};
      {3'd5, 6'b011111}: lookup = {1'b1, 8'h45};
      {3'd5, 6'b001111}: lookup = {1'b1, 8'h16};
      {3'd5, 6'b000111}: lookup = {1'b1, 8'h1E};
      {3'd5, 6'b000011}: lookup = {1'b1, 8'h26};
      {3'd5, 6'b000001}: lookup = {1'b1, 8'h25};
      {3'd5, 6'b000000}: lookup = {1'b1, 8'h2E};
      {3'd5, 6'b010000}: lookup = {1'b1, 8'h36};
      {3'd5, 6'b011000}: lookup = {1'b1, 8'h3D};
      {3'd5, 6'b011100}: lookup = {1'b1, 8'h3E};
      {3'd5, 6'b011110}: lookup = {1'b1, 8'h46};
      default:           lookup = 9'h000;
    endcase
  endfunction

  assign tab_hit = lookup(sym_len, pattern);
  assign char_ok = tab_hit[8] && !ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    append    = 1'b0;
    emit_char = 1'b0;
    emit_word = 1'b0;
    clr_buf   = 1'b0;
    case (state)
      S_IDLE: if (rise) state_nxt = S_MARK;
      S_MARK: if (fall) begin
        append    = 1'b1;
        state_nxt = S_SPACE;
      end
      S_SPACE: begin
        if ((units == 4'd3) && (sym_len != 3'd0)) begin
          emit_char = 1'b1;
          state_nxt = S_EMIT;
        end else begin
          if ((units == 4'd7) && word_pend) begin
            emit_word = 1'b1;
            state_nxt = S_IDLE;
          end
          if (rise) state_nxt = S_MARK;
        end
      end
      S_EMIT: begin
        clr_buf   = 1'b1;
        state_nxt = (key_out || rise) ? S_MARK : S_SPACE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern   <= '0;
      sym_len   <= '0;
      ovf       <= 1'b0;
      word_pend <= 1'b0;
      code_out  <= 8'h00;
      code_strb <= 1'b0;
      err_strb  <= 1'b0;
    end else begin
      code_strb <= 1'b0;
      err_strb  <= 1'b0;
      if (clr_buf) begin
        pattern <= '0;
        sym_len <= '0;
        ovf     <= 1'b0;
      end else if (append) begin
        if (sym_len == 3'd6) begin
          ovf <= 1'b1;
        end else begin
          pattern <= {pattern[4:0], is_dah};
          sym_len <= sym_len + 3'd1;
        end
      end
      if (emit_char) begin
        word_pend <= char_ok;
        if (char_ok) begin
          code_out  <= tab_hit[7:0];
          code_strb <= 1'b1;
        end else begin
          err_strb  <= 1'b1;
        end
      end else if (emit_word) begin
        word_pend <= 1'b0;
        code_out  <= 8'h29;
        code_strb <= 1'b1;
      end
    end
  end

endmodule

// File: doc/morse_code_decoder.md
# morse_code_decoder

Receive-side counterpart of the Morse encoder path. Samples a straight-key input, debounces it, and times each mark and space in dit units. Marks are classified as dits or dahs; characters are assembled from up to 6 symbols. Each completed character or word gap is emitted as a one-cycle-strobed PS/2 scan-code-set-2 make code, so downstream logic sees the same byte format the PS/2 receiver produces.

## Interface
Parameters:
- UNIT_CYCLES, default 1200000: clock cycles per dit unit (120 ms at 10 MHz).
- DEBOUNCE_CYCLES, default 50000: cycles key_in must be stable before an edge is accepted.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  1  raw straight key, 1 = key down; asynchronous to clk.
- key_out  output  1  debounced key level, for sidetone/LED.
- code_out  output  8  last emitted scan code; held between strobes.
- code_strb  output  1  one-cycle pulse when code_out is updated.
- err_strb  output  1  one-cycle pulse when a character is invalid; code_out unchanged.

## Operation
- Input path:
  - 2-flop synchronizer, reset to 0.
  - Debouncer: counter reloads on any change of the synchronized value. After DEBOUNCE_CYCLES stable cycles, key_out takes the new value.
  - The debounced rise/fall is the only edge event used downstream.
- Unit timer:
  - cyc_cnt counts 0..UNIT_CYCLES-1 and wraps.
  - Each wrap increments units (4 bits), which saturates at 15.
  - Both counters clear on every debounced edge.
- Symbol buffer:
  - pattern[5:0] and sym_len[2:0] (0..6), plus an ovf flag.
  - Each new symbol shifts into pattern LSB: 1 = dah, 0 = dit.
  - A 7th symbol sets ovf and leaves pattern/sym_len unchanged.
- FSM:
  - IDLE: key up, nothing pending. Rise -> MARK.
  - MARK: on fall, classify using units before clear. units < 2 -> dit, else dah. Append symbol -> SPACE.
  - SPACE: key up.
    - units reaches 3 with sym_len > 0 -> EMIT.
    - units reaches 7 with word_pend set -> emit 0x29 (space) with code_strb, clear word_pend -> IDLE.
    - Rise -> MARK.
  - EMIT (1 cycle):
    - If ovf, or (sym_len, pattern) is not in the table -> err_strb.
    - Otherwise code_out <= table value with code_strb, and set word_pend.
    - Always clear pattern, sym_len and ovf -> SPACE (the gap keeps timing toward the word gap).
  - If a rise coincides with the cycle units reaches 3 while symbols are pending, the character is still emitted. The new mark then starts with an empty buffer.
- Lookup table (set-2 make codes):
  - Letters: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - Digits: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46.
  - Standard ITU patterns. Everything else is invalid.
- Reset values:
  - key_out 0, code_out 8'h00, code_strb 0, err_strb 0.
  - FSM IDLE, all counters, pattern, sym_len and flags 0.
- Reset mid-mark or mid-character discards all pending symbols; nothing is emitted.
- A key held down at reset release is seen as a fresh rise after debounce.

## Timing
- Edge latency: key_in change to key_out change = 2 sync cycles + DEBOUNCE_CYCLES (+1 register).
- Symbol append: cycle after the debounced fall.
- Character: code_strb/err_strb is high exactly 1 cycle, the cycle after units becomes 3 (3*UNIT_CYCLES after the debounced fall, +1).
- Word gap: space strobe the cycle after units becomes 7. Emitted at most once per gap, and only after a valid character.
- Marks longer than 15 units saturate and remain dahs. Spaces beyond 7 units produce no further output.
- code_strb and err_strb are never high together.

## Test plan
Bench settings: UNIT_CYCLES=8, DEBOUNCE_CYCLES=2.
- Reset: hold rst_n low with key_in=1 -> all outputs 0. Release -> key_out rises after 2 sync cycles + debounce (+1 register), with no strobe.
- Letter "A": dit (1 unit), 1-unit gap, dah (3 units), key up -> code_strb with code_out=0x1C, 3 units + 1 cycle after the last fall. After 7 units -> code_strb with 0x29.
- Digit "0": 5 dahs, then gap -> 0x45. Then "E" (one dit) -> 0x24. Only 1 space strobe follows.
- Overflow: 7 dits, then gap -> err_strb only; code_out keeps its prior value; no space strobe afterward.
- Invalid pattern "..--" -> err_strb; code_out unchanged. Glitch key_in high for 1 cycle -> key_out unchanged, no symbol.
- Boundary: mark of exactly 2 units -> dah ("T" = 0x2C). Mark of 15 units and 40 units -> still "T". Assert rst_n mid-mark -> no strobe afterward.
